// File: rtl/split_access_lsu.sv
// Load/store unit between the memory stage and a handshaked data bus: lane steering,
// strobes, load extension, and two-beat splitting of accesses that cross a bus word.
module split_access_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_rwtype,
  input  logic [XLEN-1:0]   cpu_wdata,
  output logic [XLEN-1:0]   cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HALF   = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] DWORD  = 3'b011;
  localparam logic [2:0] BYTE_U = 3'b100;
  localparam logic [2:0] HALF_U = 3'b101;
  localparam logic [2:0] WORD_U = 3'b110;

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, FAULT, DONE} state_t;
  state_t state_reg;

  logic              we_reg;
  logic [2:0]        type_reg;
  logic [OW-1:0]     off_reg;
  logic              cross_reg;
  logic [NB-1:0]     be1_reg;
  logic [XLEN-1:0]   wdata1_reg;
  logic [XLEN-1:0]   rdata0_reg;

  function automatic logic [3:0] size_of(input logic [2:0] t);
    case (t)
      HALF, HALF_U: size_of = 4'd2;
      WORD, WORD_U: size_of = 4'd4;
      DWORD:        size_of = 4'd8;
      default:      size_of = 4'd1;
    endcase
  endfunction

  logic [OW-1:0]     req_off;
  logic [3:0]        req_size;
  logic              req_cross, req_mis, req_illegal, req_fault;
  logic [NB-1:0]     size_mask;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wdata_wide;

  logic [3:0]        cur_size;
  logic [XLEN-1:0]   rd_keep;
  logic [XLEN-1:0]   rd_lo, rd_hi, rd_raw, rd_ext;
  logic [2*XLEN-1:0] rd_wide;
  logic              rd_msb;

  assign cpu_ready = (state_reg == IDLE);
  assign cur_size  = size_of(type_reg);

  // Per-lane masks: lanes below the access size for the incoming and the in-flight access.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign size_mask[gi]     = (gi < int'(req_size));
      assign rd_keep[8*gi +: 8] = {8{gi < int'(cur_size)}};
    end
  endgenerate

  always_comb begin
    req_off     = cpu_addr[OW-1:0];
    req_size    = size_of(cpu_rwtype);
    req_cross   = (5'(req_off) + 5'(req_size)) > 5'(NB);
    req_mis     = (4'(req_off) & (req_size - 4'd1)) != 4'd0;
    req_illegal = (cpu_rwtype == 3'b111) || (cpu_we && cpu_rwtype[2]) ||
                  ((XLEN == 32) && ((cpu_rwtype == DWORD) || (cpu_rwtype == WORD_U)));
    req_fault   = req_illegal || (req_mis && (MISALIGN_SPLIT == 0));
    // Upper halves of the shifted mask/data are exactly what the second beat carries.
    be_wide     = {{NB{1'b0}}, size_mask} << req_off;
    wdata_wide  = {{XLEN{1'b0}}, cpu_wdata} << {req_off, 3'b000};
  end

  always_comb begin
    rd_lo   = (state_reg == WAIT1) ? rdata0_reg : mem_rdata;
    rd_hi   = (state_reg == WAIT1) ? mem_rdata : '0;
    rd_wide = {rd_hi, rd_lo} >> {off_reg, 3'b000};
    rd_raw  = rd_wide[XLEN-1:0];
    case (cur_size)
      4'd1:    rd_msb = rd_raw[7];
      4'd2:    rd_msb = rd_raw[15];
      4'd4:    rd_msb = rd_raw[31];
      default: rd_msb = rd_raw[XLEN-1];
    endcase
    rd_ext = (rd_raw & rd_keep) | ((!type_reg[2] && rd_msb) ? ~rd_keep : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      cpu_fault  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_reg     <= 1'b0;
      type_reg   <= BYTE;
      off_reg    <= '0;
      cross_reg  <= 1'b0;
      be1_reg    <= '0;
      wdata1_reg <= '0;
      rdata0_reg <= '0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_fault <= 1'b0;
      case (state_reg)
        IDLE: if (cpu_req) begin
          we_reg     <= cpu_we;
          type_reg   <= cpu_rwtype;
          off_reg    <= req_off;
          cross_reg  <= req_cross;
          be1_reg    <= be_wide[2*NB-1:NB];
          wdata1_reg <= wdata_wide[2*XLEN-1:XLEN];
          if (req_fault) begin
            state_reg <= FAULT;
          end else begin
            state_reg <= BEAT0;
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= {cpu_addr[ADDR_W-1:OW], {OW{1'b0}}};
            mem_be    <= be_wide[NB-1:0];
            mem_wdata <= wdata_wide[XLEN-1:0];
          end
        end
        BEAT0: if (mem_gnt) begin
          mem_req   <= 1'b0;
          state_reg <= WAIT0;
        end
        WAIT0: if (mem_rvalid) begin
          rdata0_reg <= mem_rdata;
          if (cross_reg) begin
            state_reg <= BEAT1;
            mem_req   <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(NB);
            mem_be    <= be1_reg;
            mem_wdata <= wdata1_reg;
          end else begin
            state_reg <= DONE;
            cpu_done  <= 1'b1;
            cpu_rdata <= we_reg ? '0 : rd_ext;
          end
        end
        BEAT1: if (mem_gnt) begin
          mem_req   <= 1'b0;
          state_reg <= WAIT1;
        end
        WAIT1: if (mem_rvalid) begin
          state_reg <= DONE;
          cpu_done  <= 1'b1;
          cpu_rdata <= we_reg ? '0 : rd_ext;
        end
        FAULT: begin
          state_reg <= DONE;
          cpu_done  <= 1'b1;
          cpu_fault <= 1'b1;
          cpu_rdata <= '0;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_split_access_lsu.sv
// Directed bench for split_access_lsu (XLEN=32): aligned, byte, split, wait-state,
// fault, back-to-back and reset-abort scenarios against a small bus responder.
module tb_split_access_lsu;
  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HALF   = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] DWORD  = 3'b011;
  localparam logic [2:0] BYTE_U = 3'b100;
  localparam logic [2:0] HALF_U = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_ready, cpu_we, cpu_done, cpu_fault;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_rwtype;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        ns_cpu_req, ns_cpu_ready, ns_cpu_we, ns_cpu_done, ns_cpu_fault;
  logic [31:0] ns_cpu_addr, ns_cpu_wdata, ns_cpu_rdata;
  logic [2:0]  ns_cpu_rwtype;
  logic        ns_mem_req, ns_mem_we;
  logic [31:0] ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_be;
  logic        ns_mem_gnt, ns_mem_rvalid;
  logic [31:0] ns_mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Bus responder state
  int          gnt_wait = 0;
  logic        inject_stale = 1'b0;
  logic [31:0] mem_model [logic [31:0]];
  int          beat_count = 0;
  logic [31:0] beat_addr [64];
  logic [3:0]  beat_be [64];
  logic [31:0] beat_wdata [64];
  logic        beat_we [64];
  logic        beat_unstable [64];
  logic        in_beat = 1'b0;
  int          wcnt = 0;
  logic        rv_pend = 1'b0;
  logic [31:0] rv_data = '0;

  split_access_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_rwtype(cpu_rwtype), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_fault(cpu_fault),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  split_access_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_nosplit (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(ns_cpu_req), .cpu_ready(ns_cpu_ready), .cpu_addr(ns_cpu_addr), .cpu_we(ns_cpu_we),
    .cpu_rwtype(ns_cpu_rwtype), .cpu_wdata(ns_cpu_wdata), .cpu_rdata(ns_cpu_rdata),
    .cpu_done(ns_cpu_done), .cpu_fault(ns_cpu_fault),
    .mem_req(ns_mem_req), .mem_gnt(ns_mem_gnt), .mem_addr(ns_mem_addr), .mem_we(ns_mem_we),
    .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata), .mem_rvalid(ns_mem_rvalid), .mem_rdata(ns_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Grants after gnt_wait waiting cycles, answers one cycle after the grant, records each beat.
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = rv_pend || inject_stale;
    mem_rdata  = rv_pend ? rv_data : 32'hBAD0_BAD0;
    rv_pend    = 1'b0;
    if (!rst_n) begin
      in_beat = 1'b0;
    end else if (mem_req) begin
      if (!in_beat) begin
        in_beat = 1'b1;
        wcnt = 0;
        beat_addr[beat_count % 64]     = mem_addr;
        beat_be[beat_count % 64]       = mem_be;
        beat_wdata[beat_count % 64]    = mem_wdata;
        beat_we[beat_count % 64]       = mem_we;
        beat_unstable[beat_count % 64] = 1'b0;
      end else if (mem_addr !== beat_addr[beat_count % 64] || mem_be !== beat_be[beat_count % 64] ||
                   mem_wdata !== beat_wdata[beat_count % 64] || mem_we !== beat_we[beat_count % 64]) begin
        beat_unstable[beat_count % 64] = 1'b1;
      end
      if (wcnt >= gnt_wait) begin
        mem_gnt = 1'b1;
        in_beat = 1'b0;
        rv_pend = 1'b1;
        rv_data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        beat_count++;
      end else begin
        wcnt++;
      end
    end
  end

  // Issues one access on the split DUT; done_k is the completion cycle relative to accept (cycle 0).
  task automatic do_access(input logic [31:0] addr, input logic we, input logic [2:0] t,
                           input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                           output int done_k, output int nb, output int first, output logic rdy_start);
    @(negedge clk);
    rdy_start  = cpu_ready;
    first      = beat_count;
    cpu_req    = 1'b1;
    cpu_addr   = addr;
    cpu_we     = we;
    cpu_rwtype = t;
    cpu_wdata  = wd;
    @(posedge clk);
    #1;
    cpu_req    = 1'b0;
    cpu_addr   = 32'hFFFF_FFFF;
    cpu_we     = ~we;
    cpu_rwtype = 3'b111;
    cpu_wdata  = 32'hA5A5_A5A5;
    done_k = -1;
    rd = 32'hXXXX_XXXX;
    flt = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (cpu_done) begin
        done_k = k;
        rd = cpu_rdata;
        flt = cpu_fault;
        break;
      end
    end
    nb = beat_count - first;
    $display("txn addr=%h we=%0b type=%0d -> done@%0d rdata=%h fault=%0b beats=%0d",
             addr, we, t, done_k, rd, flt, nb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL reset cpu_ready: got %b expected 1", cpu_ready); end
    vectors++; if (cpu_done !== 1'b0) begin miscompares++; $display("FAIL reset cpu_done: got %b expected 0", cpu_done); end
    vectors++; if (cpu_fault !== 1'b0) begin miscompares++; $display("FAIL reset cpu_fault: got %b expected 0", cpu_fault); end
    vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset cpu_rdata: got %h expected 0", cpu_rdata); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset mem_req: got %b expected 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset mem_we: got %b expected 0", mem_we); end
    vectors++; if (mem_be !== 4'h0) begin miscompares++; $display("FAIL reset mem_be: got %h expected 0", mem_be); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
  endtask

  task automatic test_word_load();
    logic [31:0] rd; logic flt, rdy; int dk, nb, f;
    gnt_wait = 0;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    do_access(32'h100, 1'b0, WORD, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (dk != 3) begin miscompares++; $display("FAIL word_load done cycle: got %0d expected 3", dk); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL word_load rdata: got %h expected deadbeef", rd); end
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL word_load fault: got %b expected 0", flt); end
    vectors++; if (nb != 1) begin miscompares++; $display("FAIL word_load beats: got %0d expected 1", nb); end
    vectors++; if (beat_be[f % 64] !== 4'b1111) begin miscompares++; $display("FAIL word_load be: got %b expected 1111", beat_be[f % 64]); end
    vectors++; if (beat_addr[f % 64] !== 32'h100) begin miscompares++; $display("FAIL word_load addr: got %h expected 00000100", beat_addr[f % 64]); end
  endtask

  task automatic test_byte_load();
    logic [31:0] rd; logic flt, rdy; int dk, nb, f;
    mem_model[32'h100] = 32'h80FF_FFFF;
    do_access(32'h103, 1'b0, BYTE, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (rd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL byte_load rdata: got %h expected ffffff80", rd); end
    vectors++; if (beat_be[f % 64] !== 4'b1000) begin miscompares++; $display("FAIL byte_load be: got %b expected 1000", beat_be[f % 64]); end
    do_access(32'h103, 1'b0, BYTE_U, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (rd !== 32'h0000_0080) begin miscompares++; $display("FAIL byte_u_load rdata: got %h expected 00000080", rd); end
    // Misaligned but inside one word: single beat, bytes 1..2
    do_access(32'h101, 1'b0, HALF, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL half_inword rdata: got %h expected ffffffff", rd); end
    vectors++; if (nb != 1 || beat_be[f % 64] !== 4'b0110) begin miscompares++; $display("FAIL half_inword beats/be: got %0d/%b expected 1/0110", nb, beat_be[f % 64]); end
  endtask

  task automatic test_split_store();
    logic [31:0] rd; logic flt, rdy; int dk, nb, f;
    do_access(32'h202, 1'b1, WORD, 32'h1122_3344, rd, flt, dk, nb, f, rdy);
    vectors++; if (nb != 2) begin miscompares++; $display("FAIL split_store beats: got %0d expected 2", nb); end
    vectors++; if (dk != 5) begin miscompares++; $display("FAIL split_store done cycle: got %0d expected 5", dk); end
    vectors++; if (beat_addr[f % 64] !== 32'h200 || beat_be[f % 64] !== 4'b1100 || beat_wdata[f % 64] !== 32'h3344_0000 || beat_we[f % 64] !== 1'b1)
      begin miscompares++; $display("FAIL split_store beat0: got %h/%b/%h/%b expected 00000200/1100/33440000/1", beat_addr[f % 64], beat_be[f % 64], beat_wdata[f % 64], beat_we[f % 64]); end
    vectors++; if (beat_addr[(f+1) % 64] !== 32'h204 || beat_be[(f+1) % 64] !== 4'b0011 || beat_wdata[(f+1) % 64] !== 32'h0000_1122 || beat_we[(f+1) % 64] !== 1'b1)
      begin miscompares++; $display("FAIL split_store beat1: got %h/%b/%h/%b expected 00000204/0011/00001122/1", beat_addr[(f+1) % 64], beat_be[(f+1) % 64], beat_wdata[(f+1) % 64], beat_we[(f+1) % 64]); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL split_store rdata: got %h expected 0", rd); end
  endtask

  task automatic test_split_load();
    logic [31:0] rd; logic flt, rdy; int dk, nb, f;
    mem_model[32'h000] = 32'hAB00_0000;
    mem_model[32'h004] = 32'h0000_00CD;
    do_access(32'h003, 1'b0, HALF, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (rd !== 32'hFFFF_CDAB) begin miscompares++; $display("FAIL split_half rdata: got %h expected ffffcdab", rd); end
    vectors++; if (dk != 5) begin miscompares++; $display("FAIL split_half done cycle: got %0d expected 5", dk); end
    vectors++; if (beat_be[f % 64] !== 4'b1000 || beat_be[(f+1) % 64] !== 4'b0001) begin miscompares++; $display("FAIL split_half be: got %b/%b expected 1000/0001", beat_be[f % 64], beat_be[(f+1) % 64]); end
    do_access(32'h003, 1'b0, HALF_U, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (rd !== 32'h0000_CDAB) begin miscompares++; $display("FAIL split_half_u rdata: got %h expected 0000cdab", rd); end
    gnt_wait = 3;
    do_access(32'h003, 1'b0, HALF, 32'h0, rd, flt, dk, nb, f, rdy);
    gnt_wait = 0;
    vectors++; if (rd !== 32'hFFFF_CDAB) begin miscompares++; $display("FAIL wait_half rdata: got %h expected ffffcdab", rd); end
    vectors++; if (dk != 11) begin miscompares++; $display("FAIL wait_half done cycle: got %0d expected 11", dk); end
    vectors++; if (beat_unstable[f % 64] !== 1'b0 || beat_unstable[(f+1) % 64] !== 1'b0)
      begin miscompares++; $display("FAIL wait_half stability: got %b/%b expected 0/0", beat_unstable[f % 64], beat_unstable[(f+1) % 64]); end
    vectors++; if (beat_addr[f % 64] !== 32'h0 || beat_addr[(f+1) % 64] !== 32'h4)
      begin miscompares++; $display("FAIL wait_half addr: got %h/%h expected 00000000/00000004", beat_addr[f % 64], beat_addr[(f+1) % 64]); end
  endtask

  task automatic test_fault();
    logic [31:0] rd; logic flt, rdy; int dk, nb, f;
    do_access(32'h100, 1'b0, DWORD, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (dk != 2 || flt !== 1'b1) begin miscompares++; $display("FAIL dword_fault done/fault: got %0d/%b expected 2/1", dk, flt); end
    vectors++; if (nb != 0 || rd !== 32'h0) begin miscompares++; $display("FAIL dword_fault beats/rdata: got %0d/%h expected 0/0", nb, rd); end
    do_access(32'h100, 1'b1, BYTE_U, 32'h55, rd, flt, dk, nb, f, rdy);
    vectors++; if (dk != 2 || flt !== 1'b1 || nb != 0) begin miscompares++; $display("FAIL ustore_fault done/fault/beats: got %0d/%b/%0d expected 2/1/0", dk, flt, nb); end
  endtask

  task automatic test_nosplit();
    logic saw_req; logic [31:0] rd; logic flt; int dk;
    @(negedge clk);
    vectors++; if (ns_cpu_ready !== 1'b1) begin miscompares++; $display("FAIL nosplit ready: got %b expected 1", ns_cpu_ready); end
    ns_cpu_req = 1'b1; ns_cpu_addr = 32'h002; ns_cpu_we = 1'b0; ns_cpu_rwtype = WORD;
    @(posedge clk);
    #1 ns_cpu_req = 1'b0;
    saw_req = 1'b0; dk = -1; rd = 32'hX; flt = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ns_mem_req) saw_req = 1'b1;
      if (ns_cpu_done && dk < 0) begin dk = k; rd = ns_cpu_rdata; flt = ns_cpu_fault; end
    end
    $display("txn nosplit addr=00000002 type=%0d -> done@%0d rdata=%h fault=%0b", WORD, dk, rd, flt);
    vectors++; if (dk != 2 || flt !== 1'b1) begin miscompares++; $display("FAIL nosplit done/fault: got %0d/%b expected 2/1", dk, flt); end
    vectors++; if (saw_req !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL nosplit mem_req/rdata: got %b/%h expected 0/0", saw_req, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic flt, rdy; int dk, nb, f;
    mem_model[32'h300] = 32'h1234_5678;
    mem_model[32'h304] = 32'h8765_4321;
    do_access(32'h300, 1'b0, WORD, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL b2b ready at done: got %b expected 0", cpu_ready); end
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL b2b first rdata: got %h expected 12345678", rd); end
    do_access(32'h306, 1'b0, HALF_U, 32'h0, rd, flt, dk, nb, f, rdy);
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL b2b ready after done: got %b expected 1", rdy); end
    vectors++; if (rd !== 32'h0000_8765 || dk != 3) begin miscompares++; $display("FAIL b2b second rdata/done: got %h/%0d expected 00008765/3", rd, dk); end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    gnt_wait = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h002; cpu_we = 1'b0; cpu_rwtype = WORD; cpu_wdata = 32'h0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(posedge clk);
    #1 gnt_wait = 1000;
    repeat (3) @(negedge clk);
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin miscompares++; $display("FAIL abort beat1 pending: got %b/%h expected 1/00000004", mem_req, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL abort mem_req: got %b expected 0", mem_req); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    gnt_wait = 0;
    @(posedge clk);
    #1 inject_stale = 1'b1;
    @(posedge clk);
    #1 inject_stale = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_done) saw_done = 1'b1;
    end
    $display("txn reset-abort split WORD load at 00000002 -> stale rvalid, done seen=%0b", saw_done);
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort stale rvalid: got done=%b expected 0", saw_done); end
    vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL abort ready: got %b expected 1", cpu_ready); end
  endtask

  initial begin
    cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_rwtype = WORD; cpu_wdata = '0;
    ns_cpu_req = 1'b0; ns_cpu_addr = '0; ns_cpu_we = 1'b0; ns_cpu_rwtype = WORD; ns_cpu_wdata = '0;
    ns_mem_gnt = 1'b0; ns_mem_rvalid = 1'b0; ns_mem_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_split_store();
    test_split_load();
    test_fault();
    test_nosplit();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/split_access_lsu.md
# split_access_lsu

Parametrised load/store unit between the pipeline's memory stage and a handshaked data-memory bus. It performs the byte-lane steering, write-strobe generation and sign/zero extension of the single-cycle memory handler, but for XLEN of 32 or 64 and against a bus with variable grant/response latency. It also splits naturally-misaligned accesses that cross a bus word into two bus beats, or faults them when splitting is disabled.

## Interface
- XLEN, 32: data and bus width; legal values 32 or 64; NB = XLEN/8 byte lanes, OW = log2(NB).
- ADDR_W, 32: address width.
- MISALIGN_SPLIT, 1: 1 = split word-crossing accesses into two beats; 0 = fault any access not naturally aligned.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; held by requester until accepted.
- cpu_ready  out  1  high in IDLE; a request is accepted on a cycle with cpu_req && cpu_ready.
- cpu_addr  in  ADDR_W  byte address.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_rwtype  in  3  `BYTE`, `BYTE_U`, `HALF`, `HALF_U`, `WORD` from definitions.sv, plus `WORD_U` and `DWORD` when XLEN=64.
- cpu_wdata  in  XLEN  store data, right-aligned.
- cpu_rdata  out  XLEN  extended load data; valid with cpu_done, held until next cpu_done.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_fault  out  1  qualifies cpu_done: misaligned (split disabled) or illegal type.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_gnt  in  1  bus accepts the beat in a cycle with mem_req.
- mem_addr  out  ADDR_W  NB-aligned beat address (low OW bits zero).
- mem_we  out  1  beat is a write.
- mem_be  out  NB  byte enables.
- mem_wdata  out  XLEN  lane-steered write data.
- mem_rvalid  in  1  beat response (reads and writes), at least one cycle after its gnt.
- mem_rdata  in  XLEN  read data, valid with mem_rvalid.

## Operation
- Decode at accept: size S = 1/2/4/8 bytes; off = addr[OW-1:0]; cross = off+S > NB; mis = off mod S != 0.
- Illegal: `DWORD`/`WORD_U` with XLEN=32, or unsigned type with cpu_we=1. Fault if illegal, or mis && MISALIGN_SPLIT=0; faulting accesses issue no bus traffic.
- States: IDLE -> (accept) BEAT0 | FAULT; BEAT0 -> (gnt) WAIT0 -> (rvalid) BEAT1 if cross else DONE; BEAT1 -> (gnt) WAIT1 -> (rvalid) DONE; FAULT -> DONE; DONE -> IDLE.
- Request fields (addr, we, type, wdata, off) are registered at accept; cpu inputs are ignored afterwards.
- Beat0: mem_addr = addr with low OW bits cleared; mem_be = ((1<<S)-1) << off, truncated to NB bits; mem_wdata = wdata << 8*off.
- Beat1: mem_addr = beat0 address + NB (wraps modulo 2^ADDR_W); mem_be = ((1<<S)-1) >> (NB-off); mem_wdata = wdata >> 8*(NB-off).
- Read assembly: raw = (rdata0 >> 8*off) | (cross ? rdata1 << 8*(NB-off) : 0); keep low S bytes; sign-extend for signed types, zero-extend for `_U`; `WORD`/`DWORD` at XLEN equal to width pass through. rdata0 is latched at beat0 rvalid.
- Stores: cpu_rdata is 0 at done. Fault: cpu_rdata = 0, cpu_fault = 1.
- mem_rvalid outside WAIT0/WAIT1 is ignored. cpu_req while cpu_ready=0 is ignored.

## Timing
- Reset values: cpu_done 0, cpu_fault 0, cpu_rdata 0, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0; state IDLE, so cpu_ready = 1.
- All outputs except cpu_ready are registered. cpu_ready = (state == IDLE).
- Accept at cycle 0. mem_req rises at cycle 1 and is held stable with all mem_* fields until the gnt cycle. It drops the cycle after gnt.
- Zero-wait aligned access: gnt in cycle 1, rvalid in cycle 2, cpu_done in cycle 3.
- Zero-wait split access: beat1 mem_req in cycle 3, rvalid in cycle 4, done in cycle 5.
- Fault: cpu_done and cpu_fault in cycle 2.
- Back-to-back: cpu_ready is 1 in the cycle after cpu_done, with one dead cycle between accesses.
- Reset mid-operation: all state clears immediately and asynchronously. mem_req falls without waiting for gnt. Late mem_rvalid from an aborted beat is ignored.

## Test plan
- XLEN=32, `WORD` load at 0x100, mem word 0xDEADBEEF, gnt at cycle 1, rvalid at cycle 2 -> one beat, mem_be=4'b1111, cpu_done at cycle 3, cpu_rdata=0xDEADBEEF.
- Load at 0x103, word 0x80FFFFFF: `BYTE` -> 0xFFFFFF80; `BYTE_U` -> 0x00000080.
- Split `WORD` store 0x11223344 at 0x202 -> beat0 addr 0x200, be 4'b1100, wdata 0x33440000; beat1 addr 0x204, be 4'b0011, wdata 0x00001122; done with rdata 0.
- Split `HALF` load at 0x003, word0 0xAB000000, word1 0x000000CD -> 0xFFFFCDAB; `HALF_U` -> 0x0000CDAB. Repeat with 3 gnt wait cycles on each beat; mem fields must stay stable while waiting.
- MISALIGN_SPLIT=0, `WORD` load at 0x002; XLEN=32, `DWORD` load -> no mem_req, cpu_done=cpu_fault=1 at cycle 2.
- Reset asserted in BEAT1 while waiting for gnt -> mem_req=0 immediately, cpu_ready=1 after release, an injected stale mem_rvalid produces no cpu_done.
